slow_to_fast_xfer: RTL and testbench
====================================

Name: slow_to_fast_xfer

Overview:
Return path for the divided-clock datapath. Results produced in the slow (divide-by-DIV) domain are sampled on a fast_clk capture strobe and buffered in a small FIFO. They are then handed to fast-domain consumers over a valid/ready handshake. Single clock (fast_clk). The slow domain is represented only by a phase counter that this block regenerates internally, so no second clock is used.

Parameters:
WIDTH, 4, data word width
DIV, 4, fast cycles per slow period; power of two, >= 2
DEPTH, 2, FIFO entries; power of two, >= 2

Ports:
fast_clk  input  1  sole clock, rising edge
rst_n  input  1  asynchronous, active-low reset
slow_data  input  WIDTH  result word from slow-domain register; stable across the whole slow period
slow_vld  input  1  slow_data holds a new result this period; stable across the slow period
out_data  output  WIDTH  FIFO head word
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts out_data this cycle
overflow  output  1  sticky: a captured word was dropped
phase  output  $clog2(DIV)  current divider phase

Behaviour:
- Reset values:
  - Assertion of rst_n=0 immediately clears phase, FIFO pointers and occupancy, overflow, and out_data.
  - out_valid=0 during reset.
- Phase counter:
  - Increments every fast_clk and wraps DIV-1 -> 0.
  - cap = (phase == DIV-1). This is one strobe per slow period, aligned with the slow-domain register update.
- Push:
  - A push occurs on a fast_clk edge where cap && slow_vld.
  - The pushed word is slow_data as seen on that edge.
  - A given slow_vld period yields at most one push.
- Pop:
  - A pop occurs on a fast_clk edge where out_valid && out_ready.
  - out_ready while out_valid=0 is ignored.
- Latency:
  - A word pushed into an empty FIFO appears on out_data with out_valid=1 in the cycle after the capture edge (1 cycle).
  - out_data and out_valid come from registers or the head entry, never combinationally from slow_data.
- Ordering: strict FIFO.
- Full condition: occupancy == DEPTH.
- Push when full:
  - With a simultaneous pop, both are performed and occupancy is unchanged.
  - Without a pop, the word is dropped, FIFO contents are unchanged, and overflow is set.
  - overflow stays set until reset.
- Empty condition: out_valid=0 and out_data holds its last value (don't-care for checkers).
- Push into an empty FIFO with out_ready=1: no bypass. The word is visible next cycle and popped no earlier than that.
- Occupancy counter is $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Reset mid-transfer: all buffered words are discarded and phase restarts at 0. The first cap after release is DIV-1 cycles later.

Optional Feature:
- Macro: SLOW_TO_FAST_XFER_CNT_EN.
- When defined:
  - Adds output xfer_count[15:0], which counts pops.
  - Resets to 0 and wraps 0xFFFF -> 0.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package xfer_pkg holds:
  - localparam WORD_W=4
  - localparam SLOW_DIV=4
  - typedef logic [WORD_W-1:0] word_t
  - typedef logic [$clog2(SLOW_DIV)-1:0] phase_t
- One sub-module is natural: xfer_fifo (parameterised WIDTH/DEPTH synchronous FIFO with push/pop/full/empty).
- The phase counter and overflow logic stay in the top.

Test Plan:
- Reset then idle with slow_vld=0 for 16 cycles -> out_valid=0, overflow=0, phase cycles 0,1,2,3,0.
- slow_data=4'hA, slow_vld=1 for one slow period, out_ready=1 -> single push at phase 3; out_valid=1 with out_data=4'hA for exactly one cycle, at the following phase 0.
- out_ready=0; push 4'h1, 4'h2, 4'h3 in consecutive slow periods -> FIFO holds 1,2; third word dropped; overflow=1; then out_ready=1 -> 4'h1 then 4'h2, out_valid drops, overflow stays 1.
- FIFO full (5,6); pop and push 4'h7 on the same cap edge -> no overflow; subsequent outputs 6 then 7.
- rst_n pulsed low mid-cycle with 2 words buffered -> out_valid=0 and phase=0 immediately; no stale words after release; the next capture occurs at phase 3.
- With SLOW_TO_FAST_XFER_CNT_EN: 5 pops -> xfer_count=5; reset -> 0.

Source files
------------

// File: rtl/slow_to_fast_xfer_pkg.sv
// Shared widths and types for the slow-to-fast result return path.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package xfer_pkg;
    localparam int WORD_W     = 4;
    localparam int SLOW_DIV   = 4;
    localparam int FIFO_DEPTH = 2;

    typedef logic [WORD_W-1:0]           word_t;
    typedef logic [$clog2(SLOW_DIV)-1:0] phase_t;
endpackage

// File: rtl/slow_to_fast_xfer_fifo.sv
// Generic synchronous FIFO; head entry drives out_dat directly.
// Latency: 1 cycle from push edge to visible head (no bypass).
// Backpressure: caller must gate push_vld with full; pop_vld with !empty.
module xfer_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             fast_clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] out_dat,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign out_dat = mem_q[rd_ptr_q];
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_vld) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_vld) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_vld, pop_vld})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head word reads as zero out of reset.
    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/slow_to_fast_xfer.sv
// Captures slow-domain results on a regenerated phase strobe into a FIFO; optional pop counter via SLOW_TO_FAST_XFER_CNT_EN.
// Latency: 1 fast cycle from capture edge to out_valid on an empty FIFO.
// Backpressure: out_valid/out_ready; a capture into a full FIFO without a same-edge pop is dropped and flags sticky overflow.
module slow_to_fast_xfer
    import xfer_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DIV   = SLOW_DIV,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                    fast_clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        slow_data,
    input  logic                    slow_vld,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overflow,
`ifdef SLOW_TO_FAST_XFER_CNT_EN
    output logic [15:0]             xfer_count,
`endif
    output logic [$clog2(DIV)-1:0]  phase
);
    localparam int PH_W = $clog2(DIV);

    logic [PH_W-1:0] phase_q, phase_d;
    logic            overflow_q, overflow_d;
    logic            cap;
    logic            push_req;
    logic            push_ok;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;

    // cap lines up with the edge on which the slow register updates.
    assign cap       = (phase_q == PH_W'(DIV - 1));
    assign push_req  = cap && slow_vld;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign push_ok   = push_req && (!fifo_full || pop);

    always_comb begin
        phase_d    = phase_q + PH_W'(1);
        overflow_d = overflow_q || (push_req && fifo_full && !pop);
    end

    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            overflow_q <= overflow_d;
        end
    end

    assign phase    = phase_q;
    assign overflow = overflow_q;

    xfer_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .fast_clk (fast_clk),
        .rst_n    (rst_n),
        .push_vld (push_ok),
        .push_dat (slow_data),
        .pop_vld  (pop),
        .out_dat  (out_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

`ifdef SLOW_TO_FAST_XFER_CNT_EN
    logic [15:0] xfer_count_q, xfer_count_d;

    always_comb begin
        xfer_count_d = xfer_count_q;
        if (pop) begin
            xfer_count_d = xfer_count_q + 16'd1;
        end
    end

    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count_q <= '0;
        end else begin
            xfer_count_q <= xfer_count_d;
        end
    end

    assign xfer_count = xfer_count_q;
`endif
endmodule

// File: tb/tb_slow_to_fast_xfer.sv
// Directed bench for slow_to_fast_xfer: reset, single transfer, overflow,
// full pop+push, mid-transfer reset and (when enabled) the pop counter.
module tb_slow_to_fast_xfer;
    logic       fast_clk = 1'b0;
    logic       rst_n    = 1'b0;
    logic [3:0] slow_data = 4'h0;
    logic       slow_vld  = 1'b0;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       overflow;
    logic [1:0] phase;
`ifdef SLOW_TO_FAST_XFER_CNT_EN
    logic [15:0] xfer_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0] exp_phase = 2'd0;

    slow_to_fast_xfer #(.WIDTH(4), .DIV(4), .DEPTH(2)) dut (
        .fast_clk  (fast_clk),
        .rst_n     (rst_n),
        .slow_data (slow_data),
        .slow_vld  (slow_vld),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
`ifdef SLOW_TO_FAST_XFER_CNT_EN
        .xfer_count(xfer_count),
`endif
        .phase     (phase)
    );

    always #5 fast_clk = ~fast_clk;

    task automatic tick();
        @(posedge fast_clk);
        if (rst_n) exp_phase = exp_phase + 2'd1;
        @(negedge fast_clk);
    endtask

    task automatic to_phase0();
        while (exp_phase != 2'd0) tick();
    endtask

    task automatic do_reset();
        @(negedge fast_clk);
        rst_n = 1'b0; slow_vld = 1'b0; out_ready = 1'b0;
        @(posedge fast_clk);
        @(negedge fast_clk);
        rst_n = 1'b1; exp_phase = 2'd0;
    endtask

    task automatic push_period(input logic [3:0] d);
        to_phase0();
        slow_data = d; slow_vld = 1'b1;
        repeat (4) tick();
        slow_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_tests++; if (phase !== 2'd0) begin n_fail++; $display("FAIL reset_phase got=%0d exp=0", phase); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        n_tests++; if (out_data !== 4'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        @(negedge fast_clk);
        rst_n = 1'b1; exp_phase = 2'd0;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_tests++; if (phase !== 2'((i + 1) % 4)) begin n_fail++; $display("FAIL idle_phase[%0d] got=%0d exp=%0d", i, phase, (i + 1) % 4); end
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_out_valid[%0d] got=%b exp=0", i, out_valid); end
        end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL idle_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_single();
        to_phase0();
        slow_data = 4'hA; slow_vld = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_pre_valid[%0d] got=%b exp=0", i, out_valid); end
        end
        tick();
        slow_vld = 1'b0;
        n_tests++; if (phase !== 2'd0) begin n_fail++; $display("FAIL single_phase got=%0d exp=0", phase); end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        n_tests++; if (out_data !== 4'hA) begin n_fail++; $display("FAIL single_data got=%h exp=a", out_data); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_post_valid[%0d] got=%b exp=0", i, out_valid); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        push_period(4'h1);
        push_period(4'h2);
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before got=%b exp=0", overflow); end
        push_period(4'h3);
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        n_tests++; if (out_data !== 4'h1) begin n_fail++; $display("FAIL ovf_head0 got=%h exp=1", out_data); end
        out_ready = 1'b1;
        tick();
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid1 got=%b exp=1", out_valid); end
        n_tests++; if (out_data !== 4'h2) begin n_fail++; $display("FAIL ovf_head1 got=%h exp=2", out_data); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drain got=%b exp=0", out_valid); end
        repeat (4) tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_no_third got=%b exp=0", out_valid); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        out_ready = 1'b0;
    endtask

    task automatic test_full_pop_push();
        do_reset();
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf_cleared got=%b exp=0", overflow); end
        push_period(4'h5);
        push_period(4'h6);
        to_phase0();
        slow_data = 4'h7; slow_vld = 1'b1;
        repeat (3) tick();
        n_tests++; if (out_data !== 4'h5) begin n_fail++; $display("FAIL fpp_head5 got=%h exp=5", out_data); end
        out_ready = 1'b1;
        tick();
        slow_vld = 1'b0;
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_no_ovf got=%b exp=0", overflow); end
        n_tests++; if (out_data !== 4'h6) begin n_fail++; $display("FAIL fpp_head6 got=%h exp=6", out_data); end
        tick();
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fpp_valid7 got=%b exp=1", out_valid); end
        n_tests++; if (out_data !== 4'h7) begin n_fail++; $display("FAIL fpp_head7 got=%h exp=7", out_data); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_empty got=%b exp=0", out_valid); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf_end got=%b exp=0", overflow); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        push_period(4'h8);
        push_period(4'h9);
        tick();
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_buffered got=%b exp=1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got=%b exp=0", out_valid); end
        n_tests++; if (phase !== 2'd0) begin n_fail++; $display("FAIL rmid_phase got=%0d exp=0", phase); end
        @(negedge fast_clk);
        rst_n = 1'b1; exp_phase = 2'd0;
        slow_data = 4'hB; slow_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale[%0d] got=%b exp=0", i, out_valid); end
        end
        n_tests++; if (phase !== 2'd3) begin n_fail++; $display("FAIL rmid_cap_phase got=%0d exp=3", phase); end
        tick();
        slow_vld = 1'b0;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_cap_valid got=%b exp=1", out_valid); end
        n_tests++; if (out_data !== 4'hB) begin n_fail++; $display("FAIL rmid_cap_data got=%h exp=b", out_data); end
        out_ready = 1'b1;
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_drain got=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

`ifdef SLOW_TO_FAST_XFER_CNT_EN
    task automatic test_count();
        do_reset();
        n_tests++; if (xfer_count !== 16'd0) begin n_fail++; $display("FAIL cnt_reset got=%0d exp=0", xfer_count); end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_period(4'(i + 1));
        tick();
        n_tests++; if (xfer_count !== 16'd5) begin n_fail++; $display("FAIL cnt_five got=%0d exp=5", xfer_count); end
        do_reset();
        n_tests++; if (xfer_count !== 16'd0) begin n_fail++; $display("FAIL cnt_cleared got=%0d exp=0", xfer_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_pop_push();
        test_reset_mid();
`ifdef SLOW_TO_FAST_XFER_CNT_EN
        test_count();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
